// File: rtl/add_ctrl_pkg.sv
// Shared types and sizing helpers for the serial slice-adder sequencer.
package add_ctrl_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_steps(input int width, input int slice);
    return width / slice;
  endfunction

  // Index counter needs at least one bit even for a single-step configuration.
  function automatic int calc_idx_w(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/serial_add16_ctrl_if.sv
// Operand/result valid-ready bundle between producer, sequencer and consumer.
interface serial_add16_ctrl_if
  import add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/serial_add16_ctrl_slice_adder.sv
// Combinational SLICE-bit ripple slice; result is {carry_out, sum_bits}.
module slice_adder #(
  parameter int SLICE = 2
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c_in,
  output logic [SLICE:0]   res
);

  assign res = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, c_in};

endmodule

// File: rtl/serial_add16_ctrl.sv
// Serial adder sequencer: reuses one SLICE-bit adder per cycle, LSB slice first,
// with valid/ready handshakes on the operand and result sides.
module serial_add16_ctrl
  import add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input logic                clk,
  input logic                rst,
  serial_add16_ctrl_if.slave bus
);

  localparam int N     = calc_steps(WIDTH, SLICE);
  localparam int IDX_W = calc_idx_w(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  generate
    if ((WIDTH % SLICE) != 0) begin : g_bad_width
      $error("serial_add16_ctrl: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  state_e                   state_r;
  state_e                   state_s;
  logic [WIDTH-1:0]         a_sh_r;
  logic [WIDTH-1:0]         b_sh_r;
  // Only the upper WIDTH-SLICE bits of the accumulator survive a step.
  logic [WIDTH-SLICE-1:0]   acc_r;
  logic [WIDTH-1:0]         acc_s;
  logic                     carry_r;
  logic [IDX_W-1:0]         idx_r;
  logic [WIDTH-1:0]         sum_r;
  logic                     cout_r;
  logic [SLICE:0]           slice_s;

  slice_adder #(.SLICE(SLICE)) u_slice (
    .a    (a_sh_r[SLICE-1:0]),
    .b    (b_sh_r[SLICE-1:0]),
    .c_in (carry_r),
    .res  (slice_s)
  );

  assign acc_s    = {slice_s[SLICE-1:0], acc_r};
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (bus.in_valid) state_s = RUN;  else state_s = IDLE;
      RUN:     if (idx_r == LAST_IDX) state_s = DONE; else state_s = RUN;
      DONE:    if (bus.out_ready) state_s = IDLE; else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the registered state only
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_r)
      IDLE:    bus.in_ready = 1'b1;
      RUN:     bus.busy     = 1'b1;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      default: bus.in_ready = 1'b0;
    endcase
  end

  // Operand shift registers, accumulator, carry, step counter and result latch
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      acc_r   <= {(WIDTH-SLICE){1'b0}};
      carry_r <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh_r  <= bus.a;
            b_sh_r  <= bus.b;
            carry_r <= bus.cin;
            idx_r   <= {IDX_W{1'b0}};
            acc_r   <= {(WIDTH-SLICE){1'b0}};
          end
        end
        RUN: begin
          a_sh_r  <= a_sh_r >> SLICE;
          b_sh_r  <= b_sh_r >> SLICE;
          acc_r   <= acc_s[WIDTH-1:SLICE];
          carry_r <= slice_s[SLICE];
          // Result is latched once so it stays put after the pop.
          if (idx_r == LAST_IDX) begin
            sum_r  <= acc_s;
            cout_r <= slice_s[SLICE];
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        default: begin
          carry_r <= carry_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add16_ctrl.sv
// Self-checking bench: arithmetic reference model plus directed and random operations.
module tb_serial_add16_ctrl;
  import add_ctrl_pkg::*;

  localparam int W = 16;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_add16_ctrl_if #(.WIDTH(W)) bus ();

  serial_add16_ctrl #(.WIDTH(W), .SLICE(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: one pending operation, result due N edges after acceptance.
  int          cyc = 0;
  bit          m_live = 1'b0;
  bit          m_pending = 1'b0;
  int          m_due = 0;
  logic [16:0] m_res = 17'd0;
  logic [16:0] m_last = 17'd0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_pending = 1'b0;
      m_last    = 17'd0;
      m_live    = 1'b1;
    end else if (m_live) begin
      if (m_pending && (cyc - 1) >= m_due && bus.out_ready) begin
        m_pending = 1'b0;
        m_last    = m_res;
      end else if (!m_pending && bus.in_valid) begin
        m_pending = 1'b1;
        m_res     = {1'b0, bus.a} + {1'b0, bus.b} + {16'd0, bus.cin};
        m_due     = cyc + N;
      end
    end
  end

  bit          c_vis;
  logic [16:0] c_exp;

  always @(negedge clk) begin
    if (m_live) begin
      c_vis = m_pending && (cyc >= m_due);
      c_exp = c_vis ? m_res : m_last;
      check("m_in_ready",  32'(bus.in_ready),  32'(!m_pending));
      check("m_out_valid", 32'(bus.out_valid), 32'(c_vis));
      check("m_busy",      32'(bus.busy),      32'(m_pending));
      check("m_sum",       32'(bus.sum),       32'(c_exp[15:0]));
      check("m_cout",      32'(bus.cout),      32'(c_exp[16]));
    end
  end

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [15:0] xs, input logic xc, input int stall,
                       input bit poke, input bit rnd_rdy);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.cin = c;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = 16'(~a);
    bus.b = 16'(~b);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      if (poke && n == 3) begin
        check("ready_busy", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.a = 16'hAAAA;
      end else begin
        bus.in_valid = 1'b0;
      end
      if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    check("latency", 32'(n), 32'(N));
    check("sum", 32'(bus.sum), 32'(xs));
    check("cout", 32'(bus.cout), 32'(xc));
    if (stall > 0) bus.out_ready = 1'b0;
    repeat (stall) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_sum", 32'(bus.sum), 32'(xs));
      check("hold_cout", 32'(bus.cout), 32'(xc));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("ready_after_pop", 32'(bus.in_ready), 32'd1);
    check("sum_kept", 32'(bus.sum), 32'(xs));
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic [16:0] rx;
    bus.in_valid  = 1'b0;
    bus.a         = 16'h0000;
    bus.b         = 16'h0000;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_sum",       32'(bus.sum),       32'd0);
    check("rst_cout",      32'(bus.cout),      32'd0);

    // Early out_ready while idle does nothing.
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.out_ready = 1'b0;
    check("idle_no_valid", 32'(bus.out_valid), 32'd0);

    do_op(16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 0, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 5, 1'b0, 1'b0);
    do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0, 1'b1, 1'b0);

    // Abort at the fourth RUN step.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 16'h0F0F;
    bus.b = 16'h1111;
    bus.cin = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready",  32'(bus.in_ready),  32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_busy",      32'(bus.busy),      32'd0);
    check("abort_sum",       32'(bus.sum),       32'd0);
    check("abort_cout",      32'(bus.cout),      32'd0);

    do_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      rx = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      do_op(ra, rb, rc, rx[15:0], rx[16], $urandom_range(0, 3), 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
